// File: rtl/simt_divergence_ctrl.sv
// Per-warp SIMT branch divergence controller.
// Turns resolved branch outcomes into SIMT stack pushes, detects reconvergence
// on issued PCs and pops the stack, owns the warp's active thread mask and
// raises one-cycle fetch redirects.
module simt_divergence_ctrl #(
    parameter int WARP_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       warp_init,
    input  logic [WARP_SIZE-1:0]       init_mask,
    input  logic                       br_valid,
    output logic                       br_ready,
    input  logic [DATA_WIDTH-1:0]      br_target,
    input  logic [DATA_WIDTH-1:0]      br_fallthrough,
    input  logic [DATA_WIDTH-1:0]      br_rpc,
    input  logic [WARP_SIZE-1:0]       br_taken_mask,
    input  logic                       issue_valid,
    input  logic [DATA_WIDTH-1:0]      issue_pc,
    output logic                       busy,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [DATA_WIDTH-1:0]      stk_push_rpc,
    output logic [DATA_WIDTH-1:0]      stk_push_npc,
    output logic [WARP_SIZE-1:0]       stk_push_mask,
    input  logic [DATA_WIDTH-1:0]      stk_top_rpc,
    input  logic [DATA_WIDTH-1:0]      stk_top_npc,
    input  logic [WARP_SIZE-1:0]       stk_top_mask,
    input  logic                       stk_empty,
    input  logic [$clog2(DEPTH):0]     stk_depth,
    output logic [WARP_SIZE-1:0]       active_mask,
    output logic                       redirect_valid,
    output logic [DATA_WIDTH-1:0]      redirect_pc,
    output logic                       overflow_err
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW:0] DEPTH_W = (DW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUSH_RC = 2'd1,
        S_PUSH_NT = 2'd2,
        S_RECHECK = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [WARP_SIZE-1:0]    active_mask_q;
    logic                    overflow_err_q;
    logic                    redirect_valid_q;
    logic [DATA_WIDTH-1:0]   redirect_pc_q;
    logic                    stk_push_q;
    logic [DATA_WIDTH-1:0]   push_rpc_q;
    logic [DATA_WIDTH-1:0]   push_npc_q;
    logic [WARP_SIZE-1:0]    push_mask_q;
    // Branch context held across the two push cycles
    logic [DATA_WIDTH-1:0]   tgt_q;
    logic [DATA_WIDTH-1:0]   fall_q;
    logic [DATA_WIDTH-1:0]   rpc_q;
    logic [WARP_SIZE-1:0]    taken_q;
    logic [WARP_SIZE-1:0]    ntaken_q;
    // PC that triggered the last pop; RECHECK compares the new top against it
    logic [DATA_WIDTH-1:0]   held_pc_q;

    logic [WARP_SIZE-1:0]    taken_s;
    logic [WARP_SIZE-1:0]    ntaken_s;
    logic                    free_ok_s;
    logic                    pop_raw_s;
    logic                    pop_s;
    logic [DATA_WIDTH-1:0]   chk_pc_s;
    logic                    br_ready_s;
    logic                    accept_s;

    // Split the incoming branch against the current mask and check for two free slots
    always_comb begin
        taken_s   = active_mask_q & br_taken_mask;
        ntaken_s  = active_mask_q & ~br_taken_mask;
        free_ok_s = (({1'b0, stk_depth}) + (DW + 1)'(2)) <= DEPTH_W;
    end

    // Reconvergence detection: issued PC in IDLE, held PC in RECHECK
    always_comb begin
        pop_raw_s = 1'b0;
        chk_pc_s  = issue_pc;
        case (state_q)
            S_IDLE: begin
                chk_pc_s  = issue_pc;
                pop_raw_s = issue_valid && !stk_empty && (stk_top_rpc == issue_pc);
            end
            S_RECHECK: begin
                chk_pc_s  = held_pc_q;
                pop_raw_s = !stk_empty && (stk_top_rpc == held_pc_q);
            end
            default: begin
                chk_pc_s  = issue_pc;
                pop_raw_s = 1'b0;
            end
        endcase
    end

    // Qualify pop and branch handshake; warp_init silences both
    always_comb begin
        pop_s      = pop_raw_s && !warp_init;
        br_ready_s = (state_q == S_IDLE) && !pop_raw_s && !warp_init;
        accept_s   = br_valid && br_ready_s;
    end

    // Main controller FSM with registered stack, mask and redirect outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            active_mask_q    <= {WARP_SIZE{1'b0}};
            overflow_err_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {DATA_WIDTH{1'b0}};
            stk_push_q       <= 1'b0;
            push_rpc_q       <= {DATA_WIDTH{1'b0}};
            push_npc_q       <= {DATA_WIDTH{1'b0}};
            push_mask_q      <= {WARP_SIZE{1'b0}};
            tgt_q            <= {DATA_WIDTH{1'b0}};
            fall_q           <= {DATA_WIDTH{1'b0}};
            rpc_q            <= {DATA_WIDTH{1'b0}};
            taken_q          <= {WARP_SIZE{1'b0}};
            ntaken_q         <= {WARP_SIZE{1'b0}};
            held_pc_q        <= {DATA_WIDTH{1'b0}};
        end else if (warp_init) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            active_mask_q    <= init_mask;
            overflow_err_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            stk_push_q       <= 1'b0;
        end else begin
            stk_push_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        active_mask_q <= stk_top_mask;
                        held_pc_q     <= issue_pc;
                        if (stk_top_npc != chk_pc_s) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= stk_top_npc;
                            state_q          <= S_IDLE;
                            busy_q           <= 1'b0;
                        end else begin
                            state_q <= S_RECHECK;
                            busy_q  <= 1'b1;
                        end
                    end else if (accept_s) begin
                        tgt_q    <= br_target;
                        fall_q   <= br_fallthrough;
                        rpc_q    <= br_rpc;
                        taken_q  <= taken_s;
                        ntaken_q <= ntaken_s;
                        if (taken_s == {WARP_SIZE{1'b0}}) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= br_fallthrough;
                        end else if (ntaken_s == {WARP_SIZE{1'b0}}) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= br_target;
                        end else if (free_ok_s) begin
                            // Reconvergence entry goes in first so it sits under the not-taken path
                            stk_push_q  <= 1'b1;
                            push_rpc_q  <= br_rpc;
                            push_npc_q  <= br_rpc;
                            push_mask_q <= active_mask_q;
                            state_q     <= S_PUSH_RC;
                            busy_q      <= 1'b1;
                        end else begin
                            // No room: keep going down the taken path only
                            overflow_err_q   <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= br_target;
                            active_mask_q    <= taken_s;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_PUSH_RC: begin
                    stk_push_q       <= 1'b1;
                    push_rpc_q       <= rpc_q;
                    push_npc_q       <= fall_q;
                    push_mask_q      <= ntaken_q;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= tgt_q;
                    state_q          <= S_PUSH_NT;
                    busy_q           <= 1'b1;
                end
                S_PUSH_NT: begin
                    active_mask_q <= taken_q;
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                end
                S_RECHECK: begin
                    if (pop_s) begin
                        active_mask_q <= stk_top_mask;
                        if (stk_top_npc != chk_pc_s) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= stk_top_npc;
                            state_q          <= S_IDLE;
                            busy_q           <= 1'b0;
                        end else begin
                            state_q <= S_RECHECK;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign br_ready       = br_ready_s;
    assign busy           = busy_q;
    assign stk_push       = stk_push_q;
    assign stk_pop        = pop_s;
    assign stk_push_rpc   = push_rpc_q;
    assign stk_push_npc   = push_npc_q;
    assign stk_push_mask  = push_mask_q;
    assign active_mask    = active_mask_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign overflow_err   = overflow_err_q;

endmodule
